// File: rtl/drp_dump_uart_tx.sv
// DRP record dump over UART.
// Each accepted (address, data) record is sent as the 11-character ASCII line
// "AAAA:DDDD\r\n", 8N1 (or 8N2), LSB first. One record is held at a time.
// Triggers that arrive while busy are dropped and counted.
module drp_dump_uart_tx #(
  parameter int C_SYS_CLK_PRD = 10,
  parameter int C_BAUD_RATE   = 115200,
  parameter int C_STOP_BITS   = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        TRIG_I,
  input  logic [15:0] ADDR_I,
  input  logic [15:0] DATA_I,
  output logic        BUSY_O,
  output logic        FINISH_O,
  output logic [7:0]  DROP_CNT_O,
  output logic        TX_O
);

  localparam int DIV = 1000000000 / (C_SYS_CLK_PRD * C_BAUD_RATE);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  // DONE occupies the final clock of the last stop bit, so a retrigger in
  // DONE starts the next start bit with no extra high time on the line.
  localparam logic [CW-1:0] LAST_CLK = CW'(DIV - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } rec_t;

  state_t         state;
  rec_t           rec;
  logic [3:0]     idx;
  logic [2:0]     bitn;
  logic           stopn;
  logic [CW-1:0]  cnt;
  logic [7:0]     ch;
  logic           accept;
  logic           stop_last;
  logic           bit_end;

  assign accept    = TRIG_I & ~BUSY_O;
  assign stop_last = (C_STOP_BITS == 1) || stopn;
  assign bit_end   = (cnt == BIT_END);

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character currently being sent, selected by the line index.
  always_comb begin
    ch = 8'h0A;
    unique case (idx)
      4'd0:    ch = hex_ascii(rec.addr[15:12]);
      4'd1:    ch = hex_ascii(rec.addr[11:8]);
      4'd2:    ch = hex_ascii(rec.addr[7:4]);
      4'd3:    ch = hex_ascii(rec.addr[3:0]);
      4'd4:    ch = 8'h3A;
      4'd5:    ch = hex_ascii(rec.data[15:12]);
      4'd6:    ch = hex_ascii(rec.data[11:8]);
      4'd7:    ch = hex_ascii(rec.data[7:4]);
      4'd8:    ch = hex_ascii(rec.data[3:0]);
      4'd9:    ch = 8'h0D;
      default: ch = 8'h0A;
    endcase
  end

  // Line FSM: bit timer, character index, registered TX/BUSY/FINISH.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state    <= IDLE;
      rec      <= '0;
      idx      <= '0;
      bitn     <= '0;
      stopn    <= 1'b0;
      cnt      <= '0;
      TX_O     <= 1'b1;
      BUSY_O   <= 1'b0;
      FINISH_O <= 1'b0;
    end else begin
      FINISH_O <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            rec    <= '{addr: ADDR_I, data: DATA_I};
            state  <= START;
            idx    <= '0;
            cnt    <= '0;
            TX_O   <= 1'b0;
            BUSY_O <= 1'b1;
          end
        end
        START: begin
          cnt <= cnt + CW'(1);
          if (bit_end) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= DATA;
            TX_O  <= ch[0];
          end
        end
        DATA: begin
          cnt <= cnt + CW'(1);
          if (bit_end) begin
            cnt <= '0;
            if (bitn == 3'd7) begin
              state <= STOP;
              stopn <= 1'b0;
              TX_O  <= 1'b1;
            end else begin
              bitn <= bitn + 3'd1;
              TX_O <= ch[bitn + 3'd1];
            end
          end
        end
        STOP: begin
          cnt <= cnt + CW'(1);
          if (stop_last && idx == 4'd10 && cnt == LAST_CLK) begin
            cnt      <= '0;
            state    <= DONE;
            BUSY_O   <= 1'b0;
            FINISH_O <= 1'b1;
          end else if (bit_end) begin
            cnt <= '0;
            if (!stop_last) begin
              stopn <= 1'b1;
            end else begin
              idx   <= idx + 4'd1;
              state <= START;
              TX_O  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of triggers rejected while busy.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)
      DROP_CNT_O <= '0;
    else if (TRIG_I && BUSY_O && DROP_CNT_O != 8'hFF)
      DROP_CNT_O <= DROP_CNT_O + 8'd1;
  end

endmodule

// File: tb/tb_drp_dump_uart_tx.sv
// Bench for drp_dump_uart_tx: two instances (1 and 2 stop bits), divisor 10.
// Expected TX waveforms are built from the expected text line, one sample
// per clock, and compared cycle by cycle.
module tb_drp_dump_uart_tx;

  localparam int DIVX = 10;  // 1e9 / (10 ns * 10 Mbaud)

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  trig;
  logic [15:0] addr, data;
  logic [1:0]  busy, fin, tx;
  logic [7:0]  drop [2];

  int tests = 0;
  int fails = 0;
  bit wq[$];

  always #5 clk = ~clk;

  drp_dump_uart_tx #(.C_SYS_CLK_PRD(10), .C_BAUD_RATE(10_000_000), .C_STOP_BITS(1)) u0 (
    .CLK_I(clk), .RST_I(rst), .TRIG_I(trig[0]), .ADDR_I(addr), .DATA_I(data),
    .BUSY_O(busy[0]), .FINISH_O(fin[0]), .DROP_CNT_O(drop[0]), .TX_O(tx[0]));

  drp_dump_uart_tx #(.C_SYS_CLK_PRD(10), .C_BAUD_RATE(10_000_000), .C_STOP_BITS(2)) u1 (
    .CLK_I(clk), .RST_I(rst), .TRIG_I(trig[1]), .ADDR_I(addr), .DATA_I(data),
    .BUSY_O(busy[1]), .FINISH_O(fin[1]), .DROP_CNT_O(drop[1]), .TX_O(tx[1]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          sel;
    string       exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference text of a record: four hex digits, colon, four hex digits.
  function automatic string line_text(input logic [15:0] a, input logic [15:0] d);
    string hx;
    string s;
    logic [31:0] v;
    hx = "0123456789ABCDEF";
    s  = "";
    v  = {a, d};
    for (int i = 0; i < 8; i++) begin
      if (i == 4) s = {s, ":"};
      s = {s, string'(hx[int'(v[31-4*i -: 4])])};
    end
    return s;
  endfunction

  // Build expected per-clock TX samples for text + CR LF.
  function automatic void build_wave(input string s, input int nstop);
    byte c [$];
    wq.delete();
    for (int i = 0; i < s.len(); i++) c.push_back(s[i]);
    c.push_back(8'h0D);
    c.push_back(8'h0A);
    foreach (c[i]) begin
      for (int b = 0; b < 9 + nstop; b++) begin
        bit lvl;
        if (b == 0)      lvl = 1'b0;
        else if (b <= 8) lvl = c[i][b-1];
        else             lvl = 1'b1;
        for (int k = 0; k < DIVX; k++) wq.push_back(lvl);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a trigger for one cycle; returns in the cycle after acceptance.
  task automatic fire(input int sel, input logic [15:0] a, input logic [15:0] d);
    addr = a; data = d; trig[sel] = 1'b1;
    step();
    trig[sel] = 1'b0;
  endtask

  // Check a whole line starting at the first start-bit cycle.
  // mode 0: plain, 1: retrigger with (a2,d2) in the finish cycle,
  // 2: trigger every 3 clocks for 300 triggers during the line.
  task automatic check_line(input int sel, input string s, input int mode,
                            input logic [15:0] a2, input logic [15:0] d2);
    int errs = 0, first = -1, fin_n = 0, fin_bad = 0, busy_bad = 0, len;
    build_wave(s, sel + 1);
    len = wq.size();
    for (int k = 0; k < len; k++) begin
      if (tx[sel] !== wq[k]) begin
        errs++;
        if (first < 0) first = k;
      end
      if (fin[sel] === 1'b1) begin
        fin_n++;
        if (k != len - 1) fin_bad++;
      end
      if (busy[sel] !== (k != len - 1)) busy_bad++;
      if (mode == 2 && k % 3 == 0 && k < 900) begin
        addr = 16'($urandom); data = 16'($urandom); trig[sel] = 1'b1;
      end
      if (mode == 1 && k == len - 1) begin
        addr = a2; data = d2; trig[sel] = 1'b1;
      end
      step();
      trig[sel] = 1'b0;
    end
    if (errs != 0) $display("  line %s sel%0d first bad sample %0d", s, sel, first);
    chk("tx_wave_errs", errs, 0);
    chk("finish_count", fin_n, 1);
    chk("finish_pos_errs", fin_bad, 0);
    chk("busy_errs", busy_bad, 0);
    if (mode != 1) begin
      chk("tx_idle_after", tx[sel], 1'b1);
      chk("busy_idle_after", busy[sel], 1'b0);
    end
  endtask

  initial begin
    vec_t tbl [8];
    int   fin_seen;

    trig = '0; addr = '0; data = '0; rst = 1'b1;
    #22;
    chk("rst_tx", tx, 2'b11);
    chk("rst_busy", busy, 2'b00);
    chk("rst_finish", fin, 2'b00);
    chk("rst_drop0", drop[0], 8'd0);
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("idle_tx", tx, 2'b11);

    tbl[0] = '{16'h028C, 16'hBEEF, 0, "028C:BEEF"};
    tbl[1] = '{16'h0000, 16'hFFFF, 0, "0000:FFFF"};
    tbl[2] = '{16'h028C, 16'hBEEF, 1, "028C:BEEF"};
    tbl[3] = '{16'hA5C3, 16'h1D9E, 1, "A5C3:1D9E"};
    for (int i = 4; i < 8; i++) begin
      tbl[i].a = 16'($urandom);
      tbl[i].d = 16'($urandom);
      tbl[i].sel = i % 2;
      tbl[i].exp = line_text(tbl[i].a, tbl[i].d);
    end

    foreach (tbl[i]) begin
      step();
      fire(tbl[i].sel, tbl[i].a, tbl[i].d);
      check_line(tbl[i].sel, tbl[i].exp, 0, '0, '0);
    end
    chk("drop_none0", drop[0], 8'd0);
    chk("drop_none1", drop[1], 8'd0);

    // Back-to-back: retrigger in the finish cycle, both stop-bit settings.
    for (int s = 0; s < 2; s++) begin
      step();
      fire(s, 16'h1234, 16'h5678);
      check_line(s, "1234:5678", 1, 16'h9ABC, 16'hDEF0);
      check_line(s, "9ABC:DEF0", 0, '0, '0);
      chk("drop_chain", drop[s], 8'd0);
    end

    // Trigger storm during one line: only first line sent, drops saturate.
    step();
    fire(0, 16'hCAFE, 16'h0042);
    check_line(0, "CAFE:0042", 2, '0, '0);
    chk("drop_saturated", drop[0], 8'd255);
    for (int k = 0; k < 50; k++) step();
    chk("storm_no_second_line", busy[0], 1'b0);

    // Reset midway through the data bits of character 5.
    step();
    fire(0, 16'h7777, 16'h3333);
    for (int k = 0; k < 545; k++) step();
    chk("pre_rst_busy", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_drop", drop[0], 8'd0);
    fin_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (fin[0] === 1'b1) fin_seen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (fin[0] === 1'b1) fin_seen++;
    end
    chk("midrst_no_finish", fin_seen, 0);
    chk("postrst_tx", tx[0], 1'b1);
    fire(0, 16'h0F1E, 16'h2D3C);
    check_line(0, "0F1E:2D3C", 0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
